// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the multi-channel programmable clock divider.
// Used by clkdiv_chan and clkdiv_multi; see clkdiv_chan for the CLKDIV_DUTY50_EN option.
package clkdiv_pkg;

  localparam int DIV_W_DEF = 8;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } chan_state_e;

  // A ratio below 2 cannot produce a distinct high and low phase, so it is lifted to 2.
  function automatic int unsigned clamp_div(input int unsigned v);
    return (v < 32'd2) ? 32'd2 : v;
  endfunction

  // Number of counter states during which the posedge phase flop is high.
  function automatic int unsigned high_cnt(input int unsigned r, input bit duty50);
    if (duty50 && r[0])
      return (r - 32'd1) / 32'd2;
    return (r + 32'd1) / 32'd2;
  endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: period counter, active/shadow ratio, pending flag and output phase.
// Build option CLKDIV_DUTY50_EN adds a negedge flop that stretches odd ratios to 50% duty.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DEF_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             en_i,
  input  logic             ld_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             clk_o,
  output logic             tick_o,
  output logic             pend_o
);

  localparam logic [DIV_W-1:0] DEF_R = DIV_W'(clamp_div(DEF_DIV));
`ifdef CLKDIV_DUTY50_EN
  localparam bit DUTY50 = 1'b1;
`else
  localparam bit DUTY50 = 1'b0;
`endif

  chan_state_e      state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] r_q, r_d;
  logic [DIV_W-1:0] sh_q, sh_d;
  logic [DIV_W-1:0] div_cl;
  logic [DIV_W-1:0] high;
  logic             pend_q, pend_d;
  logic             pos_q, pos_d;
  logic             wrap;

  assign div_cl = DIV_W'(clamp_div(32'(div_i)));
  assign wrap   = (cnt_q == (r_q - DIV_W'(1)));

  // NOTE: every signal assigned here gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    pend_d  = pend_q;
    sh_d    = ld_i ? div_cl : sh_q;

    if (!en_i) begin
      // Disabling truncates the period and lets any waiting ratio take effect immediately.
      state_d = CH_IDLE;
      cnt_d   = '0;
      r_d     = sh_d;
      pend_d  = 1'b0;
    end else if (state_q == CH_IDLE) begin
      state_d = CH_RUN;
      cnt_d   = '0;
      r_d     = sh_d;
      pend_d  = 1'b0;
    end else if (wrap) begin
      cnt_d  = '0;
      r_d    = sh_d;
      pend_d = 1'b0;
    end else begin
      cnt_d  = cnt_q + DIV_W'(1);
      pend_d = pend_q | ld_i;
    end

    high  = DIV_W'(high_cnt(32'(r_d), DUTY50));
    pos_d = (state_d == CH_RUN) && (cnt_d < high);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values;
  // all registers, including the ratio storage, have a defined reset value.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= CH_IDLE;
      cnt_q   <= '0;
      r_q     <= DEF_R;
      sh_q    <= DEF_R;
      pend_q  <= 1'b0;
      pos_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      sh_q    <= sh_d;
      pend_q  <= pend_d;
      pos_q   <= pos_d;
    end
  end

  assign tick_o = en_i && (state_q == CH_RUN) && wrap;
  assign pend_o = pend_q;

`ifdef CLKDIV_DUTY50_EN
  logic neg_q;

  // Half-cycle delayed copy of the phase; only odd ratios need the extra half period.
  always_ff @(negedge clk or negedge rst_) begin
    if (!rst_) neg_q <= 1'b0;
    else       neg_q <= pos_q & r_q[0];
  end

  assign clk_o = pos_q | (neg_q & (state_q == CH_RUN));
`else
  assign clk_o = pos_q;
`endif

endmodule

// File: rtl/clkdiv_multi.sv
// NCH independent programmable integer clock dividers with per-channel tick and pending flag.
// Optional 50% duty for odd ratios is selected with the CLKDIV_DUTY50_EN build macro.
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DEF_DIV = 2
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic [NCH-1:0]       en,
  input  logic [NCH-1:0]       ld,
  input  logic [NCH*DIV_W-1:0] div_in,
  output logic [NCH-1:0]       clk_out,
  output logic [NCH-1:0]       tick,
  output logic [NCH-1:0]       pend
);

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    clkdiv_chan #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk    (clk),
      .rst_   (rst_),
      .en_i   (en[g]),
      .ld_i   (ld[g]),
      .div_i  (div_in[g*DIV_W +: DIV_W]),
      .clk_o  (clk_out[g]),
      .tick_o (tick[g]),
      .pend_o (pend[g])
    );
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Self-checking bench for clkdiv_multi: directed scenarios with literal expectations,
// then randomized enables/loads compared every cycle against a behavioural period model.
module tb_clkdiv_multi;

  localparam int NCH     = 4;
  localparam int DIV_W   = 8;
  localparam int DEF_DIV = 2;

  logic                 clk = 1'b0;
  logic                 rst_;
  logic [NCH-1:0]       en;
  logic [NCH-1:0]       ld;
  logic [NCH*DIV_W-1:0] div_in;
  logic [NCH-1:0]       clk_out;
  logic [NCH-1:0]       tick;
  logic [NCH-1:0]       pend;

  clkdiv_multi #(.NCH(NCH), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) dut (
    .clk     (clk),
    .rst_    (rst_),
    .en      (en),
    .ld      (ld),
    .div_in  (div_in),
    .clk_out (clk_out),
    .tick    (tick),
    .pend    (pend)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: each channel is a position within a period of length m_r.
  bit m_run[NCH];
  int m_ph[NCH];
  int m_r[NCH];
  int m_sh[NCH];
  bit m_pend[NCH];
  bit m_pos[NCH];
  bit m_neg[NCH];

  function automatic int clampv(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  function automatic int hcnt(input int r);
`ifdef CLKDIV_DUTY50_EN
    if (r % 2 == 1) return (r - 1) / 2;
`endif
    return (r + 1) / 2;
  endfunction

  function automatic bit exp_clk(input int c);
    return m_pos[c] | (m_neg[c] & m_run[c]);
  endfunction

  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (!rst_) begin
        m_run[c] = 0; m_ph[c] = 0; m_r[c] = clampv(DEF_DIV); m_sh[c] = clampv(DEF_DIV);
        m_pend[c] = 0; m_pos[c] = 0; m_neg[c] = 0;
      end else begin
        int sh_n;
        sh_n = ld[c] ? clampv(int'(div_in[c*DIV_W +: DIV_W])) : m_sh[c];
        if (!en[c]) begin
          m_run[c] = 0; m_ph[c] = 0; m_r[c] = sh_n; m_pend[c] = 0;
        end else if (!m_run[c] || m_ph[c] == m_r[c] - 1) begin
          m_run[c] = 1; m_ph[c] = 0; m_r[c] = sh_n; m_pend[c] = 0;
        end else begin
          m_ph[c] = m_ph[c] + 1;
          m_pend[c] = m_pend[c] | ld[c];
        end
        m_sh[c] = sh_n;
        m_pos[c] = m_run[c] && (m_ph[c] < hcnt(m_r[c]));
      end
    end
    #1;
    if (chk_on) begin
      for (int c = 0; c < NCH; c++) begin
        check($sformatf("clk_out[%0d]", c), clk_out[c], exp_clk(c));
        check($sformatf("tick[%0d]", c), tick[c], en[c] && m_run[c] && (m_ph[c] == m_r[c] - 1));
        check($sformatf("pend[%0d]", c), pend[c], m_pend[c]);
      end
    end
  end

`ifdef CLKDIV_DUTY50_EN
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) m_neg[c] = rst_ && m_pos[c] && (m_r[c] % 2 == 1);
    #1;
    if (chk_on)
      for (int c = 0; c < NCH; c++) check($sformatf("clk_out_half[%0d]", c), clk_out[c], exp_clk(c));
  end
`endif

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int n;
    int r;
    int dv;
    rst_ = 1'b0; en = '0; ld = '0; div_in = '0;
    repeat (3) nxt();
    check("reset clk_out", clk_out, 0);
    check("reset tick", tick, 0);
    check("reset pend", pend, 0);
    rst_ = 1'b1;
    chk_on = 1'b1;

    // Channel 0 at the default ratio of 2.
    en[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nxt();
      check("t1 clk_out[0]", clk_out[0], (i % 2 == 0));
      check("t1 tick[0]", tick[0], (i % 2 == 1));
    end

    // Channel 1: idle load of 5, then enable.
    ld[1] = 1'b1; div_in[1*DIV_W +: DIV_W] = 8'd5;
    nxt();
    ld[1] = 1'b0; en[1] = 1'b1;
    check("t2 idle load pend[1]", pend[1], 0);
    for (int i = 0; i < 10; i++) begin
      nxt();
      check("t2 clk_out[1]", clk_out[1], ((i % 5) < 3));
      check("t2 tick[1]", tick[1], ((i % 5) == 4));
    end

    // Channel 2: ratio 4 running, load 8 at cnt=1.
    ld[2] = 1'b1; div_in[2*DIV_W +: DIV_W] = 8'd4;
    nxt();
    ld[2] = 1'b0; en[2] = 1'b1;
    nxt();
    nxt();
    ld[2] = 1'b1; div_in[2*DIV_W +: DIV_W] = 8'd8;
    check("t4 pend before", pend[2], 0);
    nxt();
    ld[2] = 1'b0;
    check("t4 pend cnt2", pend[2], 1);
    nxt();
    check("t4 pend cnt3", pend[2], 1);
    check("t4 tick end of R=4", tick[2], 1);
    nxt();
    check("t4 pend after wrap", pend[2], 0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) nxt();
      check("t4 clk_out[2] R=8", clk_out[2], (i < 4));
      check("t4 tick[2] R=8", tick[2], (i == 7));
    end

    // Channel 3: clamp of 0, wrap-cycle load, and double load while pending.
    ld[3] = 1'b1; div_in[3*DIV_W +: DIV_W] = 8'd0;
    nxt();
    ld[3] = 1'b0; en[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nxt();
      check("t5 clk_out[3] clamp", clk_out[3], (i % 2 == 0));
      check("t5 tick[3] clamp", tick[3], (i % 2 == 1));
    end
    ld[3] = 1'b1; div_in[3*DIV_W +: DIV_W] = 8'd3;
    for (int i = 0; i < 3; i++) begin
      nxt();
      ld[3] = 1'b0;
      check("t5 wrap load pend", pend[3], 0);
      check("t5 clk_out[3] R=3", clk_out[3], (i < 2));
      check("t5 tick[3] R=3", tick[3], (i == 2));
    end
    nxt();
    ld[3] = 1'b1; div_in[3*DIV_W +: DIV_W] = 8'd6;
    nxt();
    check("t5 pend after ld 6", pend[3], 1);
    div_in[3*DIV_W +: DIV_W] = 8'd10;
    nxt();
    ld[3] = 1'b0;
    check("t5 pend after ld 10", pend[3], 1);
    nxt();
    check("t5 pend cleared", pend[3], 0);
    n = 1;
    while (!tick[3] && n < 40) begin
      nxt();
      n++;
    end
    check("t5 period after double load", n, 10);

    // Asynchronous reset in the middle of a period.
    chk_on = 1'b0;
    #2 rst_ = 1'b0;
    #1;
    check("t6 async clk_out", clk_out, 0);
    check("t6 async tick", tick, 0);
    check("t6 async pend", pend, 0);
    en = '1;
    nxt();
    nxt();
    rst_ = 1'b1;
    chk_on = 1'b1;
    nxt();
    check("t6 first clk_out", clk_out, 4'hF);
    check("t6 first tick", tick, 4'h0);
    nxt();
    check("t6 second clk_out", clk_out, 4'h0);
    check("t6 second tick", tick, 4'hF);

    // Randomized enables, loads and ratios, checked by the model every cycle.
    for (int k = 0; k < 2500; k++) begin
      nxt();
      for (int c = 0; c < NCH; c++) begin
        if (en[c]) begin
          if ($urandom_range(0, 59) == 0) en[c] = 1'b0;
        end else if ($urandom_range(0, 4) == 0) begin
          en[c] = 1'b1;
        end
        ld[c] = ($urandom_range(0, 11) == 0);
        r = int'($urandom_range(0, 99));
        if (r < 85)      dv = int'($urandom_range(0, 12));
        else if (r < 97) dv = int'($urandom_range(13, 40));
        else             dv = int'($urandom_range(41, 255));
        div_in[c*DIV_W +: DIV_W] = DIV_W'(dv);
      end
    end
    ld = '0;
    repeat (4) nxt();
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
